// File: rtl/tilling_pkg.sv
// Package shared by the tiling stage.
//  - tilling_state_e : tile framing FSM encoding (IDLE / ACCUM / FLUSH)
//  - half_width()    : bits in one half of a core column
//  - lanes_per_half(): ELEM_W-bit lanes in one half column
package tilling_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_FLUSH = 2'd2
  } tilling_state_e;

  function automatic int half_width(input int col_w);
    return col_w / 2;
  endfunction

  function automatic int lanes_per_half(input int col_w, input int elem_w);
    return col_w / 2 / elem_w;
  endfunction

endpackage

// File: rtl/tilling_lane_add.sv
// One overlap-add lane: sum_o = prev_i + cur_i on ELEM_W bits.
// Build option: TILLING_SAT_EN
//   defined   -> unsigned saturation to all-ones, sat_o flags the clamp
//   undefined -> modulo-2^ELEM_W wrap, sat_o is constant 0
// Ports:
//   prev_i  in  ELEM_W  low-half lane of the previous column
//   cur_i   in  ELEM_W  high-half lane of the current column
//   sum_o   out ELEM_W  lane result
//   sat_o   out 1       lane saturated this add
module tilling_lane_add
  import tilling_pkg::*;
#(
  parameter int ELEM_W = 4
) (
  input  logic [ELEM_W-1:0] prev_i,
  input  logic [ELEM_W-1:0] cur_i,
  output logic [ELEM_W-1:0] sum_o,
  output logic              sat_o
);

`ifdef TILLING_SAT_EN
  logic [ELEM_W:0] full_sum;

  assign full_sum = {1'b0, prev_i} + {1'b0, cur_i};
  assign sum_o    = full_sum[ELEM_W] ? {ELEM_W{1'b1}} : full_sum[ELEM_W-1:0];
  assign sat_o    = full_sum[ELEM_W];
`else
  assign sum_o = prev_i + cur_i;
  assign sat_o = 1'b0;
`endif

endmodule

// File: rtl/tilling_machine_ola.sv
// Tiling stage with overlap-add. Gathers one column from every conv core,
// adds each column's high half onto the previous column's low half (per core,
// per lane) and emits half-width tiled columns. A tile is tile_len_i columns
// followed by one flush beat carrying the last low halves (tile_last_o=1).
// Build option: TILLING_SAT_EN (lane saturation + sticky sat_flag_o).
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; ready never depends on valid of the same interface, and a
// producer holding valid keeps its data stable until the transfer. On the
// input side "valid" is the AND of all per-core valids (gather).
//
// Ports:
//   clk_i, rst_i                   clock, synchronous active-high reset
//   tile_len_i                     columns per tile, sampled on first column (0 -> 1)
//   overlapped_column_core_i       core c column at [c*COL_W +: COL_W]
//   valid_data_core_i / ready_core_o   input handshake
//   tilling_machine_o              core c half-column at [c*COL_W/2 +: COL_W/2]
//   tilling_machine_valid_o / tilling_machine_ready_i   output handshake
//   tile_last_o                    marks the flush beat
//   sat_flag_o                     sticky saturation flag
//   state_dbg_o                    current FSM state
module tilling_machine_ola
  import tilling_pkg::*;
#(
  parameter int NUM_CORES = 4,
  parameter int COL_W     = 16,
  parameter int ELEM_W    = 4,
  parameter int CNT_W     = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic [CNT_W-1:0]               tile_len_i,
  input  logic [NUM_CORES*COL_W-1:0]     overlapped_column_core_i,
  input  logic [NUM_CORES-1:0]           valid_data_core_i,
  output logic                           ready_core_o,
  output logic [NUM_CORES*COL_W/2-1:0]   tilling_machine_o,
  output logic                           tilling_machine_valid_o,
  input  logic                           tilling_machine_ready_i,
  output logic                           tile_last_o,
  output logic                           sat_flag_o,
  output tilling_state_e                 state_dbg_o
);

  localparam int HALF_W = half_width(COL_W);
  localparam int LANES  = lanes_per_half(COL_W, ELEM_W);
  localparam int OUT_W  = NUM_CORES * HALF_W;

  tilling_state_e state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [OUT_W-1:0] prev_low_q;
  logic [OUT_W-1:0] cur_low_w;
  logic [OUT_W-1:0] sum_w;
  logic [OUT_W-1:0] out_q;
  logic             valid_q;
  logic             last_q;
  logic             sat_q;
  logic [NUM_CORES*LANES-1:0] sat_w;

  logic slot_free;
  logic accept;
  logic flush_fire;

  // Output register can take a new beat when empty or being drained now.
  assign slot_free    = !valid_q || tilling_machine_ready_i;
  assign ready_core_o = (state_q != ST_FLUSH) && slot_free;
  assign accept       = ready_core_o && (&valid_data_core_i);
  assign flush_fire   = (state_q == ST_FLUSH) && slot_free;

  for (genvar c = 0; c < NUM_CORES; c++) begin : g_core
    assign cur_low_w[c*HALF_W +: HALF_W] = overlapped_column_core_i[c*COL_W +: HALF_W];
    for (genvar k = 0; k < LANES; k++) begin : g_lane
      tilling_lane_add #(.ELEM_W(ELEM_W)) u_lane (
        .prev_i (prev_low_q[c*HALF_W + k*ELEM_W +: ELEM_W]),
        .cur_i  (overlapped_column_core_i[c*COL_W + HALF_W + k*ELEM_W +: ELEM_W]),
        .sum_o  (sum_w[c*HALF_W + k*ELEM_W +: ELEM_W]),
        .sat_o  (sat_w[c*LANES + k])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          len_d   = (tile_len_i == '0) ? CNT_W'(1) : tile_len_i;
          cnt_d   = CNT_W'(1);
          state_d = (len_d == CNT_W'(1)) ? ST_FLUSH : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_d == len_q) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (flush_fire) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
    end
  end

  // prev_low is zero whenever a tile starts (cleared by reset and by the
  // flush beat), so the first column of a tile needs no special case.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_low_q <= '0;
      out_q      <= '0;
      valid_q    <= 1'b0;
      last_q     <= 1'b0;
      sat_q      <= 1'b0;
    end else if (accept) begin
      out_q      <= sum_w;
      valid_q    <= 1'b1;
      last_q     <= 1'b0;
      prev_low_q <= cur_low_w;
      sat_q      <= sat_q | (|sat_w);
    end else if (flush_fire) begin
      out_q      <= prev_low_q;
      valid_q    <= 1'b1;
      last_q     <= 1'b1;
      prev_low_q <= '0;
    end else if (tilling_machine_ready_i) begin
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end
  end

  assign tilling_machine_o       = out_q;
  assign tilling_machine_valid_o = valid_q;
  assign tile_last_o             = last_q;
  assign sat_flag_o              = sat_q;
  assign state_dbg_o             = state_q;

endmodule

// File: tb/tb_tilling_machine_ola.sv
module tb_tilling_machine_ola;
  import tilling_pkg::*;

  localparam int NUM_CORES = 4;
  localparam int COL_W     = 16;
  localparam int ELEM_W    = 4;
  localparam int CNT_W     = 8;
  localparam int HALF_W    = COL_W / 2;
  localparam int LANES     = HALF_W / ELEM_W;
  localparam int OUT_W     = NUM_CORES * HALF_W;
  localparam int IN_W      = NUM_CORES * COL_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_i;
  logic [CNT_W-1:0]     tile_len;
  logic [IN_W-1:0]      col;
  logic [NUM_CORES-1:0] valid_in;
  logic                 ready_core;
  logic [OUT_W-1:0]     out_data;
  logic                 out_valid;
  logic                 out_ready;
  logic                 out_last;
  logic                 sat_flag;
  tilling_state_e       state_dbg;

  tilling_machine_ola #(
    .NUM_CORES(NUM_CORES), .COL_W(COL_W), .ELEM_W(ELEM_W), .CNT_W(CNT_W)
  ) dut (
    .clk_i                    (clk),
    .rst_i                    (rst_i),
    .tile_len_i               (tile_len),
    .overlapped_column_core_i (col),
    .valid_data_core_i        (valid_in),
    .ready_core_o             (ready_core),
    .tilling_machine_o        (out_data),
    .tilling_machine_valid_o  (out_valid),
    .tilling_machine_ready_i  (out_ready),
    .tile_last_o              (out_last),
    .sat_flag_o               (sat_flag),
    .state_dbg_o              (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [OUT_W:0] exp_q[$];     // {last, data}

  bit             m_in_tile = 0;
  int             m_len = 0;
  int             m_cnt = 0;
  logic [OUT_W-1:0] m_prev = '0;
  bit             m_sat = 0;    // any lane overflow since reset
  int             n_accepted = 0;
  bit             hold_pend = 0;
  logic [OUT_W:0] held;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [HALF_W-1:0] lane_sum(input logic [HALF_W-1:0] a,
                                                 input logic [HALF_W-1:0] b,
                                                 output bit ov);
    logic [ELEM_W:0] s;
    lane_sum = '0;
    ov = 0;
    for (int k = 0; k < LANES; k++) begin
      s = {1'b0, a[k*ELEM_W +: ELEM_W]} + {1'b0, b[k*ELEM_W +: ELEM_W]};
      ov |= s[ELEM_W];
`ifdef TILLING_SAT_EN
      lane_sum[k*ELEM_W +: ELEM_W] = s[ELEM_W] ? {ELEM_W{1'b1}} : s[ELEM_W-1:0];
`else
      lane_sum[k*ELEM_W +: ELEM_W] = s[ELEM_W-1:0];
`endif
    end
  endfunction

  function automatic bit exp_sat_flag();
`ifdef TILLING_SAT_EN
    return m_sat;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_accept();
    logic [OUT_W-1:0] beat;
    bit ov;
    if (!m_in_tile) begin
      m_len     = (tile_len == 0) ? 1 : int'(tile_len);
      m_cnt     = 0;
      m_prev    = '0;
      m_in_tile = 1;
    end
    for (int c = 0; c < NUM_CORES; c++) begin
      beat[c*HALF_W +: HALF_W] = lane_sum(m_prev[c*HALF_W +: HALF_W],
                                          col[c*COL_W + HALF_W +: HALF_W], ov);
      m_sat |= ov;
    end
    exp_q.push_back({1'b0, beat});
    for (int c = 0; c < NUM_CORES; c++) m_prev[c*HALF_W +: HALF_W] = col[c*COL_W +: HALF_W];
    m_cnt++;
    if (m_cnt == m_len) begin
      exp_q.push_back({1'b1, m_prev});
      m_prev    = '0;
      m_in_tile = 0;
    end
    n_accepted++;
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_in_tile = 0;
    m_prev    = '0;
    m_sat     = 0;
    hold_pend = 0;
  endtask

  // One clock: sample at negedge, update scoreboard, return at posedge+1.
  task automatic cycle();
    @(negedge clk);
    if (rst_i) begin
      hold_pend = 0;
    end else begin
      if (hold_pend) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_beat", {out_last, out_data}, held);
      end
      if (out_valid === 1'b1 && out_ready) begin
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL unexpected_beat observed=%0h expected=none", {out_last, out_data});
        end
        if (exp_q.size() > 0) check("beat", {out_last, out_data}, exp_q.pop_front());
      end
      hold_pend = (out_valid === 1'b1) && !out_ready;
      held      = {out_last, out_data};
      if (ready_core === 1'b1 && (&valid_in)) model_accept();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    valid_in  = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 50 && exp_q.size() > 0; i++) cycle();
    check("drain_empty", exp_q.size(), 0);
    cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int target;
    rst_i     = 1'b1;
    valid_in  = '1;
    col       = '0;
    tile_len  = 8'd3;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // 1: reset with all valids high
    repeat (3) cycle();
    check("rst_valid", out_valid, 1'b0);
    check("rst_ready", ready_core, 1'b1);
    check("rst_data", out_data, '0);
    check("rst_last", out_last, 1'b0);
    check("rst_sat", sat_flag, 1'b0);
    check("rst_state", state_dbg, ST_IDLE);
    valid_in = '0;
    rst_i    = 1'b0;
    cycle();

    // 2: tile of 3, high lanes 1, low lanes 2
    tile_len = 8'd3;
    col      = {NUM_CORES{16'h1122}};
    valid_in = '1;
    check("t2_ready0", ready_core, 1'b1);
    cycle();
    tile_len = 8'd1;              // ignored mid-tile
    check("t2_b0", out_data, 32'h1111_1111);
    check("t2_v0", out_valid, 1'b1);
    check("t2_st0", state_dbg, ST_ACCUM);
    cycle();
    check("t2_b1", out_data, 32'h3333_3333);
    check("t2_ready1", ready_core, 1'b1);
    cycle();
    check("t2_b2", out_data, 32'h3333_3333);
    check("t2_ready_flush", ready_core, 1'b0);
    check("t2_st_flush", state_dbg, ST_FLUSH);
    valid_in = '0;
    cycle();
    check("t2_flush", out_data, 32'h2222_2222);
    check("t2_last", out_last, 1'b1);
    check("t2_ready_back", ready_core, 1'b1);
    cycle();
    check("t2_idle_valid", out_valid, 1'b0);
    check("t2_empty", exp_q.size(), 0);

    // 3: partial valid mask stalls
    tile_len = 8'd2;
    col      = 64'h0123_4567_89AB_CDEF;
    valid_in = 4'b1011;
    repeat (5) begin
      cycle();
      check("t3_no_out", out_valid, 1'b0);
      check("t3_state", state_dbg, ST_IDLE);
    end
    valid_in = 4'b1111;
    cycle();
    check("t3_accept", out_valid, 1'b1);
    col = 64'hFEDC_BA98_7654_3210;
    cycle();
    drain();

    // 5: lane overflow F + 2
    tile_len = 8'd2;
    col      = {NUM_CORES{16'h00FF}};
    valid_in = '1;
    cycle();
    col = {NUM_CORES{16'h2200}};
    cycle();
`ifdef TILLING_SAT_EN
    check("t5_sum", out_data, 32'hFFFF_FFFF);
    check("t5_sat", sat_flag, 1'b1);
`else
    check("t5_sum", out_data, 32'h1111_1111);
    check("t5_sat", sat_flag, 1'b0);
`endif
    drain();

    // 6: reset during column 2 of 4
    tile_len = 8'd4;
    col      = {NUM_CORES{16'h3344}};
    valid_in = '1;
    cycle();
    rst_i = 1'b1;
    cycle();
    model_reset();
    rst_i    = 1'b0;
    valid_in = '0;
    check("t6_valid", out_valid, 1'b0);
    check("t6_state", state_dbg, ST_IDLE);
    check("t6_sat", sat_flag, 1'b0);
    tile_len = 8'd2;
    col      = {NUM_CORES{16'h5566}};
    valid_in = '1;
    cycle();
    check("t6_first", out_data, 32'h5555_5555);
    col = '0;
    cycle();
    drain();

    // 4: backpressure mid-tile, then random traffic
    tile_len = 8'd6;
    valid_in = '1;
    repeat (2) begin
      col = {$urandom, $urandom};
      cycle();
    end
    out_ready = 1'b0;
    repeat (4) begin
      col = {$urandom, $urandom};
      cycle();
      check("t4_ready_core", ready_core, 1'b0);
      check("t4_valid", out_valid, 1'b1);
    end
    target = n_accepted + 1000;
    for (int i = 0; i < 20000 && n_accepted < target; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      valid_in  = ($urandom_range(0, 9) < 7) ? 4'hF : 4'($urandom_range(0, 15));
      col       = {$urandom, $urandom};
      tile_len  = 8'($urandom_range(0, 5));
      cycle();
    end
    check("t4_budget", n_accepted >= target, 1'b1);
    drain();
    check("final_sat", sat_flag, exp_sat_flag());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
